// File: rtl/kbd_gui_pkg.sv
// Shared definitions for the keyboard renderer GUI blocks.
//   - Colour constants (3-bit RGB, one bit per channel): BLACK, WHITE, RED.
//   - kbd_state_e: renderer FSM states.
//   - min_width(): counter width helper that never returns zero.
package kbd_gui_pkg;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] RED   = 3'b100;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SNAP,
        ST_DRAW,
        ST_DONE
    } kbd_state_e;

    // Width of a counter holding 0..n-1; at least one bit, so n == 1 stays legal.
    function automatic int min_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster scan counter for the keyboard renderer.
// Scans x fastest (0..SCREEN_W-1), then y. It also keeps the key index and the
// column inside the current key as counters stepped with x, so the renderer
// never needs a divider.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   clear          : restart the scan at pixel (0,0)
//   advance        : current pixel accepted, step to the next one
//   x, y           : current (registered) pixel position
//   x_nxt          : x after this cycle's update
//   key_nxt        : key index after this cycle's update
//   col_nxt        : in-key column after this cycle's update
//   last           : current pixel is (SCREEN_W-1, SCREEN_H-1)
//   border_nxt     : next pixel lies on the frame edge
//                    (only with KEYBOARD_RENDERER_BORDER_EN defined)
module raster_counter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int KEY_W    = 40,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int KW       = 2,
    parameter int CW       = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [XW-1:0] x_nxt,
    output logic [KW-1:0] key_nxt,
    output logic [CW-1:0] col_nxt,
    output logic          last
`ifdef KEYBOARD_RENDERER_BORDER_EN
    ,
    output logic          border_nxt
`endif
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [KW-1:0] key_q, key_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        key_d = key_q;
        col_d = col_q;
        if (clear) begin
            x_d   = '0;
            y_d   = '0;
            key_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (x_q == XW'(SCREEN_W - 1)) begin
                // End of a row: every horizontal counter restarts together.
                x_d   = '0;
                key_d = '0;
                col_d = '0;
                y_d   = (y_q == YW'(SCREEN_H - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
                if (col_q == CW'(KEY_W - 1)) begin
                    col_d = '0;
                    key_d = key_q + KW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            key_q <= '0;
            col_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            key_q <= key_d;
            col_q <= col_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign x_nxt   = x_d;
    assign key_nxt = key_d;
    assign col_nxt = col_d;
    assign last    = (x_q == XW'(SCREEN_W - 1)) && (y_q == YW'(SCREEN_H - 1));

`ifdef KEYBOARD_RENDERER_BORDER_EN
    assign border_nxt = (x_d == '0) || (y_d == '0) ||
                        (x_d == XW'(SCREEN_W - 1)) || (y_d == YW'(SCREEN_H - 1));
`endif

endmodule

// File: rtl/keyboard_renderer.sv
// Keyboard renderer: draws NUM_KEYS vertical keys across a SCREEN_W x SCREEN_H
// frame, streaming one pixel per accepted cycle to a pixel sink.
// Pressed keys are filled with PRESS_COLOUR, released keys white, and the last
// column of every key except the rightmost is a black divider. A frame is
// drawn after reset, whenever keys differ from the last drawn snapshot, and on
// force_redraw (pulses arriving while busy are remembered and collapse to one).
// Optional feature macro: KEYBOARD_RENDERER_BORDER_EN draws a black one-pixel
// border around the frame, overriding every other colour rule.
// Ports:
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   keys            : key state, bit i high = key i pressed
//   force_redraw    : single-cycle full-redraw request
//   ready           : sink accepts the pixel when plot && ready
//   x, y, colour    : pixel position and RGB colour (registered)
//   plot            : pixel valid (registered)
//   busy            : frame in progress (registered)
//   frame_done      : one-cycle pulse after the last pixel is accepted
//   state_dbg       : current FSM state, for observation only
// Handshake: a pixel transfers on a rising edge where plot && ready are both
// high; while plot is high and ready is low, x, y and colour hold unchanged,
// and plot never drops until the pixel has been accepted.
module keyboard_renderer
    import kbd_gui_pkg::*;
#(
    parameter int         NUM_KEYS     = 4,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] PRESS_COLOUR = RED
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_KEYS-1:0]         keys,
    input  logic                        force_redraw,
    input  logic                        ready,
    output logic [$clog2(SCREEN_W)-1:0] x,
    output logic [$clog2(SCREEN_H)-1:0] y,
    output logic [2:0]                  colour,
    output logic                        plot,
    output logic                        busy,
    output logic                        frame_done,
    output kbd_state_e                  state_dbg
);

    localparam int KEY_W = SCREEN_W / NUM_KEYS;
    localparam int XW    = $clog2(SCREEN_W);
    localparam int YW    = $clog2(SCREEN_H);
    localparam int KW    = min_width(NUM_KEYS);
    localparam int CW    = min_width(KEY_W);

    if (NUM_KEYS < 2 || NUM_KEYS > 16) begin : g_bad_num_keys
        $error("keyboard_renderer: NUM_KEYS must be in 2..16");
    end
    if (SCREEN_W % NUM_KEYS != 0) begin : g_bad_screen_w
        $error("keyboard_renderer: SCREEN_W must be a multiple of NUM_KEYS");
    end

    kbd_state_e          state_q, state_d;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic                pend_q, pend_d;
    logic [2:0]          colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                clear;
    logic                advance;
    logic [XW-1:0]       x_nxt;
    logic [KW-1:0]       key_nxt;
    logic [CW-1:0]       col_nxt;
    logic                last;
    logic [NUM_KEYS-1:0] pix_snap;
    logic [2:0]          pix_colour;
`ifdef KEYBOARD_RENDERER_BORDER_EN
    logic                border_nxt;
`endif

    raster_counter #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .KEY_W    (KEY_W),
        .XW       (XW),
        .YW       (YW),
        .KW       (KW),
        .CW       (CW)
    ) u_raster (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .advance    (advance),
        .x          (x),
        .y          (y),
        .x_nxt      (x_nxt),
        .key_nxt    (key_nxt),
        .col_nxt    (col_nxt),
        .last       (last)
`ifdef KEYBOARD_RENDERER_BORDER_EN
        ,
        .border_nxt (border_nxt)
`endif
    );

    assign clear   = (state_q == ST_SNAP);
    assign advance = (state_q == ST_DRAW) && plot_q && ready;

    // Colour of the pixel the counter moves to this cycle, so the registered
    // colour lines up with the registered x/y. In SNAP the snapshot register
    // is still being loaded, so the live keys are used.
    always_comb begin
        pix_snap = (state_q == ST_SNAP) ? keys : snap_q;
        if ((col_nxt == CW'(KEY_W - 1)) && (x_nxt != XW'(SCREEN_W - 1))) begin
            pix_colour = BLACK;
        end else if (pix_snap[key_nxt]) begin
            pix_colour = PRESS_COLOUR;
        end else begin
            pix_colour = WHITE;
        end
`ifdef KEYBOARD_RENDERER_BORDER_EN
        if (border_nxt) begin
            pix_colour = BLACK;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        pend_d   = pend_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        // A redraw request that IDLE cannot act on right now is kept for later.
        if (force_redraw && (state_q != ST_IDLE)) begin
            pend_d = 1'b1;
        end

        case (state_q)
            ST_INIT: begin
                state_d = ST_SNAP;
            end
            ST_IDLE: begin
                if ((keys != snap_q) || force_redraw || pend_q) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                snap_d   = keys;
                state_d  = ST_DRAW;
                plot_d   = 1'b1;
                busy_d   = 1'b1;
                colour_d = pix_colour;
            end
            ST_DRAW: begin
                plot_d = 1'b1;
                busy_d = 1'b1;
                if (advance && last) begin
                    state_d = ST_DONE;
                    plot_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    colour_d = pix_colour;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Entering SNAP serves every request seen so far.
        if (state_d == ST_SNAP) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_INIT;
            snap_q   <= '0;
            pend_q   <= 1'b0;
            colour_q <= BLACK;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            pend_q   <= pend_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign colour     = colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign state_dbg  = state_q;

endmodule
